periph_bridge: RTL and testbench
================================

PERIPH_BRIDGE -- requirements
Module: periph_bridge

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 2000, clk_i cycles per 7-segment digit slot.
REQ-002 SHALL have parameter TICK_DIV, default 100000, clk_i cycles per timer increment.
REQ-003 SHALL have port clk_i  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port Bus_addr  in  32  CPU byte address.
REQ-006 SHALL have port Bus_wen  in  1  CPU write strobe.
REQ-007 SHALL have port Bus_wdata  in  32  CPU write data.
REQ-008 SHALL have port Bus_rdata  out  32  read data back to CPU.
REQ-009 SHALL have port dram_addr  out  14  DRAM word address, equal to Bus_addr[15:2].
REQ-010 SHALL have port dram_rdata  in  32  DRAM read data.
REQ-011 SHALL have port dram_wen  out  1  DRAM write enable.
REQ-012 SHALL have port dram_wdata  out  32  DRAM write data, equal to Bus_wdata.
REQ-013 SHALL have port sw_i  in  24  asynchronous board switches.
REQ-014 SHALL have port led_o  out  24  LED register.
REQ-015 SHALL have port dig_en_o  out  8  digit enables, active-low one-hot.
REQ-016 SHALL have port seg_o  out  8  segments {dp,g..a}, active-low; dp always 1.

Function
REQ-017 SHALL decode the peripheral page as Bus_addr[31:12]==20'hFFFFF; all other addresses are DRAM.
REQ-018 SHALL map DIG=0xFFFFF000 (R/W), TIMER=0xFFFFF020 (R/W), LED=0xFFFFF060 (R/W), SW=0xFFFFF070 (R).
REQ-019 SHALL drive Bus_rdata combinationally in the same cycle: DRAM region -> dram_rdata; mapped register -> its value zero-extended; unmapped page address -> 0.
REQ-020 SHALL assert dram_wen = Bus_wen only for DRAM-region addresses; peripheral-page writes never reach DRAM.
REQ-021 SHALL update DIG or LED on the clk_i edge where Bus_wen=1 and the address matches; LED stores Bus_wdata[23:0].
REQ-022 SHALL ignore writes to SW and to unmapped page addresses.
REQ-023 SHALL pass sw_i through a two-flop synchroniser; SW reads return the second flop, so a switch change is visible 2 cycles later.
REQ-024 SHALL run a scan counter 0..SCAN_DIV-1; on reaching SCAN_DIV-1 it wraps to 0 and the digit index (3 bits) increments, wrapping 7->0.
REQ-025 SHALL drive dig_en_o with bit [index] low, all others high; seg_o decodes hex nibble DIG[4*index+3:4*index] (0-F glyphs).
REQ-026 SHALL run a timer prescaler 0..TICK_DIV-1; at TICK_DIV-1 it wraps and the 32-bit TIMER increments modulo 2^32 (0xFFFFFFFF -> 0).
REQ-027 SHALL, on a TIMER write, load Bus_wdata and clear the prescaler; a write coinciding with a tick wins, tick discarded.

Reset
REQ-028 SHALL, on rst_i=1 at a clock edge, clear DIG, LED, TIMER, prescaler, scan counter, digit index and synchroniser flops to 0, ignoring Bus_wen that cycle.
REQ-029 SHALL present after reset led_o=0, dig_en_o=8'hFE, seg_o=8'hC0 (glyph 0); reset asserted mid-scan or mid-tick restarts both counters from 0.

Configuration
REQ-030 SHALL compile the timer (REQ-026/027) only when macro PERIPH_TIMER_EN is defined.
REQ-031 SHALL, without PERIPH_TIMER_EN, omit timer and prescaler flops; TIMER reads return 0 and writes are ignored.

Structure
REQ-032 SHALL take the page base, register offsets and 7-segment glyph table from the shared defines package.
REQ-033 SHALL place scan counter, digit index and hex decode in one sub-module seg_scanner (inputs clk_i, rst_i, 32-bit value; outputs dig_en_o, seg_o).

Verification
REQ-034 SHALL test: write 0x12345678 to DIG, SCAN_DIV=4 -> dig_en_o steps FE,FD,...,7F every 4 cycles, seg_o=F9 (1) when dig_en_o=7F (digit 7 shows nibble 1), wraps to FE.
REQ-035 SHALL test: Bus_wen=1 addr 0x00000010 data 0xDEADBEEF -> dram_wen=1, dram_addr=4; same data at 0xFFFFF060 -> dram_wen=0, led_o=0xADBEEF next cycle.
REQ-036 SHALL test: sw_i=0xABCDEF, read 0xFFFFF070 -> 0 for first two cycles, 0x00ABCDEF from cycle 2 on.
REQ-037 SHALL test (PERIPH_TIMER_EN, TICK_DIV=3): write 0xFFFFFFFE -> reads FFFFFFFE, FFFFFFFF, 00000000 at 3-cycle intervals; write on tick cycle loads written value exactly.
REQ-038 SHALL test: read 0xFFFFF100 -> 0; assert rst_i mid-scan with LED=0x5 -> led_o=0, dig_en_o=FE next cycle; without PERIPH_TIMER_EN TIMER read -> 0.

Source files
------------

// File: rtl/periph_bridge_pkg.sv
// Shared definitions for the peripheral bridge: peripheral page base,
// register offsets, address decode and the 7-segment glyph table.
// The timer register is only implemented when PERIPH_TIMER_EN is defined.
package periph_bridge_pkg;

   localparam logic [19:0] PAGE_BASE = 20'hFFFFF;

   localparam logic [11:0] OFF_DIG   = 12'h000;
   localparam logic [11:0] OFF_TIMER = 12'h020;
   localparam logic [11:0] OFF_LED   = 12'h060;
   localparam logic [11:0] OFF_SW    = 12'h070;

   typedef enum logic [2:0] {
      SEL_DRAM,
      SEL_DIG,
      SEL_TIMER,
      SEL_LED,
      SEL_SW,
      SEL_NONE
   } reg_sel_t;

   // Anything outside the peripheral page is DRAM; inside the page only
   // exact register offsets select a register.
   function automatic reg_sel_t decode_addr(input logic [31:0] addr);
      reg_sel_t sel;
      if (addr[31:12] != PAGE_BASE) begin
         sel = SEL_DRAM;
      end else begin
         case (addr[11:0])
            OFF_DIG:   sel = SEL_DIG;
            OFF_TIMER: sel = SEL_TIMER;
            OFF_LED:   sel = SEL_LED;
            OFF_SW:    sel = SEL_SW;
            default:   sel = SEL_NONE;
         endcase
      end
      return sel;
   endfunction

   // Hex glyphs as {g,f,e,d,c,b,a}, active-low.
   function automatic logic [6:0] seg_glyph(input logic [3:0] nibble);
      logic [6:0] glyph;
      case (nibble)
         4'h0: glyph = 7'h40;
         4'h1: glyph = 7'h79;
         4'h2: glyph = 7'h24;
         4'h3: glyph = 7'h30;
         4'h4: glyph = 7'h19;
         4'h5: glyph = 7'h12;
         4'h6: glyph = 7'h02;
         4'h7: glyph = 7'h78;
         4'h8: glyph = 7'h00;
         4'h9: glyph = 7'h10;
         4'hA: glyph = 7'h08;
         4'hB: glyph = 7'h03;
         4'hC: glyph = 7'h46;
         4'hD: glyph = 7'h21;
         4'hE: glyph = 7'h06;
         default: glyph = 7'h0E;
      endcase
      return glyph;
   endfunction

endpackage

// File: rtl/periph_bridge_seg_scanner.sv
// Multiplexed 8-digit 7-segment driver: a scan counter dwells SCAN_DIV
// cycles on each digit, then the digit index advances 0..7 and wraps.
module seg_scanner
   import periph_bridge_pkg::*;
#(
   parameter int SCAN_DIV = 2000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] value,
   output logic [7:0]  dig_en_o,
   output logic [7:0]  seg_o
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

   logic [CW-1:0] scan_cnt;
   logic [2:0]    digit_idx;
   logic [3:0]    nibble;

   // Dwell counter; each wrap moves on to the next digit.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         scan_cnt  <= '0;
         digit_idx <= '0;
      end else if (scan_cnt == SCAN_LAST) begin
         scan_cnt  <= '0;
         digit_idx <= digit_idx + 3'd1;
      end else begin
         scan_cnt  <= scan_cnt + 1'b1;
      end
   end

   // Enable the current digit (active-low) and show its nibble; dp stays off.
   always_comb begin
      dig_en_o            = 8'hFF;
      dig_en_o[digit_idx] = 1'b0;
      nibble              = value[{digit_idx, 2'b00} +: 4];
      seg_o               = {1'b1, seg_glyph(nibble)};
   end

endmodule

// File: rtl/periph_bridge.sv
// CPU bus bridge splitting accesses between DRAM and a small peripheral
// page (7-segment digits, LEDs, switches, optional free-running timer).
// Define PERIPH_TIMER_EN to build the timer; otherwise TIMER reads as 0.
module periph_bridge
   import periph_bridge_pkg::*;
#(
   parameter int SCAN_DIV = 2000,
   parameter int TICK_DIV = 100000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] Bus_addr,
   input  logic        Bus_wen,
   input  logic [31:0] Bus_wdata,
   output logic [31:0] Bus_rdata,
   output logic [13:0] dram_addr,
   input  logic [31:0] dram_rdata,
   output logic        dram_wen,
   output logic [31:0] dram_wdata,
   input  logic [23:0] sw_i,
   output logic [23:0] led_o,
   output logic [7:0]  dig_en_o,
   output logic [7:0]  seg_o
);

   if (SCAN_DIV < 1 || TICK_DIV < 1) begin : g_bad_params
      $error("periph_bridge: SCAN_DIV and TICK_DIV must be at least 1");
   end

   reg_sel_t    sel;
   logic [31:0] dig_q;
   logic [23:0] led_q;
   logic [23:0] sw_meta;
   logic [23:0] sw_sync;
   logic [31:0] timer_value;

   assign sel        = decode_addr(Bus_addr);
   assign dram_addr  = Bus_addr[15:2];
   assign dram_wdata = Bus_wdata;
   assign dram_wen   = Bus_wen && (sel == SEL_DRAM);
   assign led_o      = led_q;

   // Writable display and LED registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         dig_q <= '0;
         led_q <= '0;
      end else if (Bus_wen) begin
         if (sel == SEL_DIG) dig_q <= Bus_wdata;
         if (sel == SEL_LED) led_q <= Bus_wdata[23:0];
      end
   end

   // Two-flop synchroniser for the asynchronous switches.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sw_meta <= '0;
         sw_sync <= '0;
      end else begin
         sw_meta <= sw_i;
         sw_sync <= sw_meta;
      end
   end

`ifdef PERIPH_TIMER_EN
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   logic [TW-1:0] presc;
   logic [31:0]   timer_q;

   // Prescaled timer; a CPU write reloads it and restarts the prescaler,
   // discarding any tick that lands on the same edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         presc   <= '0;
         timer_q <= '0;
      end else if (Bus_wen && (sel == SEL_TIMER)) begin
         presc   <= '0;
         timer_q <= Bus_wdata;
      end else if (presc == TICK_LAST) begin
         presc   <= '0;
         timer_q <= timer_q + 32'd1;
      end else begin
         presc   <= presc + 1'b1;
      end
   end

   assign timer_value = timer_q;
`else
   assign timer_value = '0;
`endif

   // Same-cycle read mux; unmapped page addresses read as zero.
   always_comb begin
      Bus_rdata = '0;
      case (sel)
         SEL_DRAM:  Bus_rdata = dram_rdata;
         SEL_DIG:   Bus_rdata = dig_q;
         SEL_TIMER: Bus_rdata = timer_value;
         SEL_LED:   Bus_rdata = {8'h00, led_q};
         SEL_SW:    Bus_rdata = {8'h00, sw_sync};
         default:   Bus_rdata = '0;
      endcase
   end

   seg_scanner #(
      .SCAN_DIV (SCAN_DIV)
   ) u_seg_scanner (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .value    (dig_q),
      .dig_en_o (dig_en_o),
      .seg_o    (seg_o)
   );

endmodule

// File: tb/tb_periph_bridge.sv
// Scoreboard bench for periph_bridge with SCAN_DIV=4 and TICK_DIV=3.
// Timer checks run only when PERIPH_TIMER_EN is defined.
module tb_periph_bridge;

   localparam int SIG_RDATA      = 0;
   localparam int SIG_DRAM_WEN   = 1;
   localparam int SIG_DRAM_ADDR  = 2;
   localparam int SIG_DRAM_WDATA = 3;
   localparam int SIG_LED        = 4;
   localparam int SIG_DIGEN      = 5;
   localparam int SIG_SEG        = 6;

   typedef struct {
      string       name;
      int          sig;
      int          due;
      logic [31:0] value;
   } expEntry_t;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] busAddr;
   logic        busWen;
   logic [31:0] busWdata;
   logic [31:0] busRdata;
   logic [13:0] dramAddr;
   logic [31:0] dramRdata;
   logic        dramWen;
   logic [31:0] dramWdata;
   logic [23:0] swIn;
   logic [23:0] ledOut;
   logic [7:0]  digEn;
   logic [7:0]  segOut;

   int          cycleCount = 0;
   int          checkCount = 0;
   int          errorCount = 0;
   expEntry_t   sbQueue[$];

   periph_bridge #(
      .SCAN_DIV (4),
      .TICK_DIV (3)
   ) dut (
      .clk_i      (clock),
      .rst_i      (reset),
      .Bus_addr   (busAddr),
      .Bus_wen    (busWen),
      .Bus_wdata  (busWdata),
      .Bus_rdata  (busRdata),
      .dram_addr  (dramAddr),
      .dram_rdata (dramRdata),
      .dram_wen   (dramWen),
      .dram_wdata (dramWdata),
      .sw_i       (swIn),
      .led_o      (ledOut),
      .dig_en_o   (digEn),
      .seg_o      (segOut)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clock = ~clock;

   // Cycle index used to schedule expected values.
   always @(posedge clock) cycleCount <= cycleCount + 1;

   task automatic applyStimulus(input logic [31:0] addr, input logic wen, input logic [31:0] wdata);
      busAddr  = addr;
      busWen   = wen;
      busWdata = wdata;
   endtask

   // Schedule an expected value for 'delay' cycles after the current one.
   task automatic checkOutput(input string name, input int sig, input int delay, input logic [31:0] value);
      expEntry_t e;
      e.name  = name;
      e.sig   = sig;
      e.due   = cycleCount + delay;
      e.value = value;
      sbQueue.push_back(e);
   endtask

   function automatic logic [31:0] sampleSig(input int sig);
      case (sig)
         SIG_RDATA:      return busRdata;
         SIG_DRAM_WEN:   return {31'd0, dramWen};
         SIG_DRAM_ADDR:  return {18'd0, dramAddr};
         SIG_DRAM_WDATA: return dramWdata;
         SIG_LED:        return {8'd0, ledOut};
         SIG_DIGEN:      return {24'd0, digEn};
         default:        return {24'd0, segOut};
      endcase
   endfunction

   // Monitor: mid-low-phase, compare every expectation due this cycle.
   always @(negedge clock) begin
      logic [31:0] actual;
      #2;
      for (int i = sbQueue.size() - 1; i >= 0; i--) begin
         if (sbQueue[i].due <= cycleCount) begin
            checkCount++;
            actual = sampleSig(sbQueue[i].sig);
            if (sbQueue[i].due < cycleCount) begin
               errorCount++;
               $display("[TB] FAIL %s: missed sample at cycle %0d, expected 0x%08h",
                        sbQueue[i].name, sbQueue[i].due, sbQueue[i].value);
            end else if (actual !== sbQueue[i].value) begin
               errorCount++;
               $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
                        sbQueue[i].name, actual, sbQueue[i].value, cycleCount);
            end
            sbQueue.delete(i);
         end
      end
   end

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed stimulus.
   initial begin
      logic [7:0] digEnTbl [8];
      logic [7:0] segTbl   [8];
      int base;
      digEnTbl = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
      segTbl   = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};

      reset     = 1'b1;
      swIn      = 24'h0;
      dramRdata = 32'h0;
      applyStimulus(32'h0, 1'b0, 32'h0);
      repeat (3) @(negedge clock);

      // Reset release, DIG write, and the full scan schedule.
      base  = cycleCount;
      reset = 1'b0;
      applyStimulus(32'hFFFFF000, 1'b1, 32'h12345678);
      checkOutput("reset_led", SIG_LED, 0, 32'h0);
      checkOutput("reset_digen", SIG_DIGEN, 0, 32'hFE);
      checkOutput("reset_seg", SIG_SEG, 0, 32'hC0);
      checkOutput("reset_dig_read", SIG_RDATA, 0, 32'h0);
      for (int k = 0; k <= 8; k++) begin
         checkOutput("scan_digen", SIG_DIGEN, 1 + 4 * k, {24'd0, digEnTbl[k % 8]});
         checkOutput("scan_seg", SIG_SEG, 1 + 4 * k, {24'd0, segTbl[k % 8]});
      end
      checkOutput("scan_dwell_end", SIG_DIGEN, 3, 32'hFE);
      checkOutput("scan_step", SIG_DIGEN, 4, 32'hFD);

      @(negedge clock);
      dramRdata = 32'h11223344;
      applyStimulus(32'h00000010, 1'b1, 32'hDEADBEEF);
      checkOutput("dram_wen", SIG_DRAM_WEN, 0, 32'h1);
      checkOutput("dram_addr", SIG_DRAM_ADDR, 0, 32'h4);
      checkOutput("dram_wdata", SIG_DRAM_WDATA, 0, 32'hDEADBEEF);
      checkOutput("dram_read", SIG_RDATA, 0, 32'h11223344);

      @(negedge clock);
      applyStimulus(32'hFFFFF060, 1'b1, 32'hDEADBEEF);
      checkOutput("led_no_dram_wen", SIG_DRAM_WEN, 0, 32'h0);
      checkOutput("led_write", SIG_LED, 1, 32'h00ADBEEF);

      @(negedge clock);
      applyStimulus(32'hFFFFF060, 1'b0, 32'h0);
      checkOutput("led_read", SIG_RDATA, 0, 32'h00ADBEEF);

      @(negedge clock);
      applyStimulus(32'hFFFFF000, 1'b0, 32'h0);
      checkOutput("dig_read", SIG_RDATA, 0, 32'h12345678);

      @(negedge clock);
      applyStimulus(32'hFFFFF070, 1'b1, 32'hFFFFFFFF);
      checkOutput("sw_write_no_dram", SIG_DRAM_WEN, 0, 32'h0);
      checkOutput("sw_write_ignored", SIG_RDATA, 1, 32'h0);

      @(negedge clock);
      applyStimulus(32'hFFFFF100, 1'b1, 32'hFFFFFFFF);
      checkOutput("unmapped_read", SIG_RDATA, 0, 32'h0);
      checkOutput("unmapped_no_dram", SIG_DRAM_WEN, 0, 32'h0);
      checkOutput("unmapped_led_kept", SIG_LED, 1, 32'h00ADBEEF);

      @(negedge clock);
      applyStimulus(32'hFFFFF000, 1'b0, 32'h0);
      checkOutput("dig_kept", SIG_RDATA, 0, 32'h12345678);

      @(negedge clock);
      swIn = 24'hABCDEF;
      applyStimulus(32'hFFFFF070, 1'b0, 32'h0);
      checkOutput("sw_sync_c0", SIG_RDATA, 0, 32'h0);
      checkOutput("sw_sync_c1", SIG_RDATA, 1, 32'h0);
      checkOutput("sw_sync_c2", SIG_RDATA, 2, 32'h00ABCDEF);
      checkOutput("sw_sync_c3", SIG_RDATA, 3, 32'h00ABCDEF);
      repeat (3) @(negedge clock);

      @(negedge clock);
`ifdef PERIPH_TIMER_EN
      applyStimulus(32'hFFFFF020, 1'b1, 32'hFFFFFFFE);
      checkOutput("timer_load", SIG_RDATA, 1, 32'hFFFFFFFE);
      checkOutput("timer_hold", SIG_RDATA, 3, 32'hFFFFFFFE);
      checkOutput("timer_inc", SIG_RDATA, 4, 32'hFFFFFFFF);
      checkOutput("timer_hold2", SIG_RDATA, 6, 32'hFFFFFFFF);
      checkOutput("timer_wrap", SIG_RDATA, 7, 32'h00000000);
      @(negedge clock);
      applyStimulus(32'hFFFFF020, 1'b0, 32'h0);
      repeat (8) @(negedge clock);
      applyStimulus(32'hFFFFF020, 1'b1, 32'hCAFE0001);
      checkOutput("timer_pre_tick", SIG_RDATA, 0, 32'h00000000);
      checkOutput("timer_write_wins", SIG_RDATA, 1, 32'hCAFE0001);
      checkOutput("timer_presc_cleared", SIG_RDATA, 3, 32'hCAFE0001);
      checkOutput("timer_after_reload", SIG_RDATA, 4, 32'hCAFE0002);
      @(negedge clock);
      applyStimulus(32'hFFFFF020, 1'b0, 32'h0);
`else
      applyStimulus(32'hFFFFF020, 1'b1, 32'h12345678);
      checkOutput("timer_absent_read", SIG_RDATA, 0, 32'h0);
      checkOutput("timer_absent_no_dram", SIG_DRAM_WEN, 0, 32'h0);
      @(negedge clock);
      applyStimulus(32'hFFFFF020, 1'b0, 32'h0);
      checkOutput("timer_absent_after_write", SIG_RDATA, 0, 32'h0);
`endif

      for (int i = 0; i < 100 && cycleCount < base + 36; i++) @(negedge clock);

      // LED set, then reset mid-scan with a write that must be ignored.
      applyStimulus(32'hFFFFF060, 1'b1, 32'h00000005);
      @(negedge clock);
      applyStimulus(32'hFFFFF070, 1'b0, 32'h0);
      checkOutput("led_five", SIG_LED, 0, 32'h5);
      @(negedge clock);
      reset = 1'b1;
      applyStimulus(32'hFFFFF060, 1'b1, 32'h00FFFFFF);
      checkOutput("pre_reset_digen", SIG_DIGEN, 0, 32'hFD);
      checkOutput("pre_reset_seg", SIG_SEG, 0, 32'hF8);
      checkOutput("mid_reset_led", SIG_LED, 1, 32'h0);
      checkOutput("mid_reset_digen", SIG_DIGEN, 1, 32'hFE);
      checkOutput("mid_reset_seg", SIG_SEG, 1, 32'hC0);
      @(negedge clock);
      reset = 1'b0;
      applyStimulus(32'hFFFFF070, 1'b0, 32'h0);
      checkOutput("sync_cleared_c0", SIG_RDATA, 0, 32'h0);
      checkOutput("sync_cleared_c1", SIG_RDATA, 1, 32'h0);
      checkOutput("sync_refill", SIG_RDATA, 2, 32'h00ABCDEF);
      checkOutput("scan_restart_hold", SIG_DIGEN, 3, 32'hFE);
      checkOutput("scan_restart_step", SIG_DIGEN, 4, 32'hFD);

      for (int i = 0; i < 20 && sbQueue.size() > 0; i++) begin
         @(negedge clock);
         #3;
      end
      foreach (sbQueue[i]) begin
         checkCount++;
         errorCount++;
         $display("[TB] FAIL %s: got no sample, expected 0x%08h", sbQueue[i].name, sbQueue[i].value);
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
